tmp121_ascii_fmt: RTL and testbench
===================================

Name: tmp121_ascii_fmt

Overview:
- Consumes the 13-bit two's-complement temperature word from the TMP121 SPI reader (LSB = 0.0625 °C).
- Produces a fixed-format ASCII record, e.g. "+025.0625\r\n", one byte at a time over a valid/ready handshake into the UART transmitter.
- Sits between the SPI reader's dout and the UART TX data input.
- Conversion is sequential (shift/add-3 BCD); there are no dividers.

Parameters:
- CRLF, 1, when 1 append CR (0x0D) and LF (0x0A) to each record; when 0 the record ends after the last fractional digit.
- ZERO_PAD, 1, when 1 leading integer zeros print as '0'; when 0 they print as ' ' (0x20). The units digit always prints as a digit.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- temp  in  13  temperature word, two's complement, value/16 = °C.
- start  in  1  one-cycle request to format and send temp. Sampled on the clk rising edge.
- busy  out  1  high from start acceptance until the last byte is handed off.
- tx_data  out  8  ASCII byte to the UART.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART can take a byte. A transfer occurs on a clk edge where tx_valid and tx_ready are both high.

Behaviour:
- Reset: asynchronous, active-high. While rst is high: busy=0, tx_valid=0, tx_data=0x00, FSM=IDLE, all capture/BCD registers cleared. Assertion mid-record aborts the record immediately and no further bytes are sent. After release the block waits for a new start.
- FSM states:
  - IDLE: busy=0, tx_valid=0. start=1 latches temp and goes to CONV. busy=1 from the next cycle.
  - CONV:
    - sign = temp[12]; mag = sign ? -temp : temp, 13-bit unsigned, so 0x1000 → 4096.
    - ipart = mag[12:4] (0..256) → 3 BCD digits via 9-iteration double-dabble, one iteration per cycle.
    - fpart = mag[3:0]*625 (0..9375, 14 bits, computed by shift-add) → 4 BCD digits via 14-iteration double-dabble.
    - The two conversions may run in parallel. CONV lasts at most 16 cycles.
    - First tx_valid must be asserted no later than 18 cycles after the start edge.
  - SEND: a byte index steps through the record.
    - Record order: sign ('+' 0x2B if sign=0, '-' 0x2D if sign=1), hundreds, tens, units, '.' (0x2E), f1, f2, f3, f4, then CR, LF if CRLF=1.
    - Record length is 11 bytes with CRLF=1, 9 with CRLF=0.
    - Digits are 0x30+BCD. Blanking applies only to hundreds (when 0) and to tens (when hundreds and tens are both 0), and only if ZERO_PAD=0.
  - After the final transfer: go to IDLE, with tx_valid=0 and busy=0 on the next cycle.
- Handshake rules:
  - Once tx_valid rises, tx_data and tx_valid hold stable until the transfer completes.
  - tx_valid must not depend combinationally on tx_ready.
  - Back-to-back transfers are allowed: when tx_ready is held high, one byte moves per cycle.
- Sign of zero: temp=0 → '+'. Negative values whose integer part is zero still print '-'.
- start while busy=1 is ignored. temp changes after capture do not affect the record in progress.
- start and rst deassertion on the same edge: start is ignored.
- No overflow case exists: full 13-bit range −256.0000 .. +255.9375 is representable.

Test Plan:
- temp=0x0190 (400), start pulse, tx_ready=1 → bytes "+025.0000\r\n" (2B 30 32 35 2E 30 30 30 30 0D 0A), busy low 1 cycle after the LF transfer.
- temp=0x1FFF → "-000.0625\r\n". temp=0x1000 → "-256.0000\r\n". temp=0x07FF → "+127.9375\r\n". temp=0x1C90 → "-055.0000\r\n". temp=0x0960 → "+150.0000\r\n".
- ZERO_PAD=0, CRLF=0, temp=0x0050 (5.0) → "+  5.0000" (2B 20 20 35 2E 30 30 30 30), 9 bytes, no CR/LF.
- Backpressure:
  - Stimulus: temp=0x0190; tx_ready toggles low for 1..5 random cycles between grants.
  - Required: tx_data/tx_valid stable while tx_ready=0, exact same byte sequence as the first scenario, no byte duplicated or dropped.
- Overlapping start: second start with temp=0x0960 issued 3 cycles after the first (temp=0x0190) → only "+025.0000\r\n" is sent. A start after busy falls sends "+150.0000\r\n".
- Reset mid-record: assert rst asynchronously after the 4th byte transfer → tx_valid and busy go low without waiting for a clk edge. After release, no bytes until the next start. A new start with temp=0x1FFF sends a complete "-000.0625\r\n".

Source files
------------

// File: rtl/tmp121_ascii_fmt.sv
// Formats a TMP121 13-bit temperature word as a fixed-width ASCII record and
// streams it byte by byte over a valid/ready handshake to a UART transmitter.
module tmp121_ascii_fmt #(
   parameter int CRLF     = 1,
   parameter int ZERO_PAD = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [12:0] temp,
   input  logic        start,
   output logic        busy,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   typedef enum logic [1:0] {IDLE, CONV, SEND} state_t;

   localparam logic [3:0] LAST_IDX = (CRLF != 0) ? 4'd10 : 4'd8;

   state_t      state;
   logic        armed;
   logic        sign;
   logic [8:0]  ibin;
   logic [11:0] ibcd;
   logic [13:0] fbin;
   logic [15:0] fbcd;
   logic [3:0]  iter;
   logic [3:0]  idx;

   logic [12:0] mag_in;
   logic [13:0] frac_x;
   logic [13:0] frac_in;
   logic [11:0] ibcd_adj;
   logic [15:0] fbcd_adj;

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   // Blanking of leading integer zeros only ever touches hundreds and tens.
   function automatic logic [7:0] rec_byte(input logic [3:0] i, input logic s,
                                           input logic [11:0] ib, input logic [15:0] fb);
      logic blank_h;
      logic blank_t;
      logic [7:0] b;
      blank_h = (ZERO_PAD == 0) && (ib[11:8] == 4'd0);
      blank_t = blank_h && (ib[7:4] == 4'd0);
      case (i)
         4'd0:    b = s ? 8'h2D : 8'h2B;
         4'd1:    b = blank_h ? 8'h20 : {4'h3, ib[11:8]};
         4'd2:    b = blank_t ? 8'h20 : {4'h3, ib[7:4]};
         4'd3:    b = {4'h3, ib[3:0]};
         4'd4:    b = 8'h2E;
         4'd5:    b = {4'h3, fb[15:12]};
         4'd6:    b = {4'h3, fb[11:8]};
         4'd7:    b = {4'h3, fb[7:4]};
         4'd8:    b = {4'h3, fb[3:0]};
         4'd9:    b = 8'h0D;
         4'd10:   b = 8'h0A;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   // Magnitude and fraction*625 via shifts; 625 = 512 + 64 + 32 + 16 + 1.
   always_comb begin
      mag_in   = temp[12] ? (~temp + 13'd1) : temp;
      frac_x   = {10'd0, mag_in[3:0]};
      frac_in  = (frac_x << 9) + (frac_x << 6) + (frac_x << 5) + (frac_x << 4) + frac_x;
      ibcd_adj = {add3(ibcd[11:8]), add3(ibcd[7:4]), add3(ibcd[3:0])};
      fbcd_adj = {add3(fbcd[15:12]), add3(fbcd[11:8]), add3(fbcd[7:4]), add3(fbcd[3:0])};
   end

   // armed stays low on the first edge after reset release so a start
   // coinciding with that edge is ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         armed    <= 1'b0;
         sign     <= 1'b0;
         ibin     <= '0;
         ibcd     <= '0;
         fbin     <= '0;
         fbcd     <= '0;
         iter     <= '0;
         idx      <= '0;
         busy     <= 1'b0;
         tx_valid <= 1'b0;
         tx_data  <= 8'h00;
      end else begin
         armed <= 1'b1;
         case (state)
            IDLE: begin
               if (start && armed) begin
                  sign  <= temp[12];
                  ibin  <= mag_in[12:4];
                  ibcd  <= '0;
                  fbin  <= frac_in;
                  fbcd  <= '0;
                  iter  <= '0;
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= CONV;
               end
            end
            // Integer runs 9 double-dabble steps, fraction 14, side by side.
            CONV: begin
               if (iter < 4'd9) begin
                  ibcd <= {ibcd_adj[10:0], ibin[8]};
                  ibin <= {ibin[7:0], 1'b0};
               end
               fbcd <= {fbcd_adj[14:0], fbin[13]};
               fbin <= {fbin[12:0], 1'b0};
               iter <= iter + 4'd1;
               if (iter == 4'd13) begin
                  state <= SEND;
               end
            end
            SEND: begin
               if (!tx_valid) begin
                  tx_valid <= 1'b1;
                  tx_data  <= rec_byte(idx, sign, ibcd, fbcd);
               end else if (tx_ready) begin
                  if (idx == LAST_IDX) begin
                     tx_valid <= 1'b0;
                     tx_data  <= 8'h00;
                     busy     <= 1'b0;
                     idx      <= '0;
                     state    <= IDLE;
                  end else begin
                     idx     <= idx + 4'd1;
                     tx_data <= rec_byte(idx + 4'd1, sign, ibcd, fbcd);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tmp121_ascii_fmt.sv
// Table-driven bench for tmp121_ascii_fmt: one instance with CRLF/zero padding,
// one without, plus backpressure, overlapping start and mid-record reset.
module tb_tmp121_ascii_fmt;

   logic        clk = 1'b0;
   logic        rst;
   logic [12:0] temp_a, temp_b;
   logic        start_a, start_b;
   logic        ready_a, ready_b;
   logic        busy_a, busy_b;
   logic        valid_a, valid_b;
   logic [7:0]  data_a, data_b;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [12:0] temp;
      int          which;
      int          len;
      logic [87:0] bytes;
   } vec_t;

   vec_t vecs[12];

   tmp121_ascii_fmt #(.CRLF(1), .ZERO_PAD(1)) dut_a (
      .clk(clk), .rst(rst), .temp(temp_a), .start(start_a), .busy(busy_a),
      .tx_data(data_a), .tx_valid(valid_a), .tx_ready(ready_a)
   );

   tmp121_ascii_fmt #(.CRLF(0), .ZERO_PAD(0)) dut_b (
      .clk(clk), .rst(rst), .temp(temp_b), .start(start_b), .busy(busy_b),
      .tx_data(data_b), .tx_valid(valid_b), .tx_ready(ready_b)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Hard stop in case something below never returns.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input int which, input logic [12:0] t);
      @(negedge clk);
      if (which == 0) begin temp_a = t; start_a = 1'b1; end
      else begin temp_b = t; start_b = 1'b1; end
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      checkOutput("busy_after_start", 32'(which == 0 ? busy_a : busy_b), 32'd1);
   endtask

   // Takes stop_after bytes; ready is driven at negedges so a grant seen here
   // transfers on the following rising edge.
   task automatic collectRecord(input string name, input int which, input int n,
                                input logic [87:0] exp, input bit backpressure,
                                input int stop_after, input bit check_lat);
      int got = 0;
      int cycles = 0;
      int low_cnt = 0;
      bit seen = 0;
      logic pend = 1'b0;
      logic [7:0] prev = 8'h00;
      logic [7:0] d;
      logic v, r;
      while (got < stop_after && cycles < 300) begin
         @(negedge clk);
         cycles++;
         v = (which == 0) ? valid_a : valid_b;
         d = (which == 0) ? data_a : data_b;
         if (v && !seen && check_lat) begin
            seen = 1;
            checkOutput($sformatf("%s_latency_ok", name), 32'(cycles <= 18), 32'd1);
         end
         if (pend)
            checkOutput($sformatf("%s_hold", name), {23'd0, v, d}, {23'd0, 1'b1, prev});
         if (backpressure && low_cnt > 0) begin
            r = 1'b0;
            low_cnt--;
         end else begin
            r = 1'b1;
         end
         if (which == 0) ready_a = r; else ready_b = r;
         if (v && r) begin
            checkOutput($sformatf("%s_byte%0d", name, got), 32'(d), 32'(exp[87-8*got -: 8]));
            got++;
            pend = 1'b0;
            if (backpressure) low_cnt = $urandom_range(1, 5);
         end else begin
            pend = v;
            prev = d;
         end
      end
      if (got < stop_after)
         checkOutput($sformatf("%s_timeout_bytes", name), 32'(got), 32'(stop_after));
      if (which == 0) ready_a = 1'b1; else ready_b = 1'b1;
      if (stop_after == n) begin
         @(negedge clk);
         if (which == 0)
            checkOutput($sformatf("%s_idle_after", name), {30'd0, busy_a, valid_a}, 32'd0);
         else
            checkOutput($sformatf("%s_idle_after", name), {30'd0, busy_b, valid_b}, 32'd0);
      end
   endtask

   initial begin
      int quiet;
      vecs[0]  = '{13'h0190, 0, 11, 88'h2B3032352E303030300D0A};
      vecs[1]  = '{13'h1FFF, 0, 11, 88'h2D3030302E303632350D0A};
      vecs[2]  = '{13'h1000, 0, 11, 88'h2D3235362E303030300D0A};
      vecs[3]  = '{13'h07FF, 0, 11, 88'h2B3132372E393337350D0A};
      vecs[4]  = '{13'h1C90, 0, 11, 88'h2D3035352E303030300D0A};
      vecs[5]  = '{13'h0960, 0, 11, 88'h2B3135302E303030300D0A};
      vecs[6]  = '{13'h0000, 0, 11, 88'h2B3030302E303030300D0A};
      vecs[7]  = '{13'h0FFF, 0, 11, 88'h2B3235352E393337350D0A};
      vecs[8]  = '{13'h0050, 1, 9,  88'h2B2020352E303030300000};
      vecs[9]  = '{13'h1FFF, 1, 9,  88'h2D2020302E303632350000};
      vecs[10] = '{13'h0190, 1, 9,  88'h2B2032352E303030300000};
      vecs[11] = '{13'h0960, 1, 9,  88'h2B3135302E303030300000};

      rst = 1'b1;
      temp_a = '0; temp_b = '0;
      start_a = 1'b0; start_b = 1'b0;
      ready_a = 1'b1; ready_b = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset_a", {23'd0, busy_a, valid_a, data_a}, 32'd0);
      checkOutput("reset_b", {23'd0, busy_b, valid_b, data_b}, 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].which, vecs[i].temp);
         collectRecord($sformatf("vec%0d", i), vecs[i].which, vecs[i].len,
                       vecs[i].bytes, 1'b0, vecs[i].len, 1'b1);
      end

      applyStimulus(0, 13'h0190);
      collectRecord("backpressure", 0, 11, vecs[0].bytes, 1'b1, 11, 1'b0);

      // Second start three edges after the first must be dropped.
      applyStimulus(0, 13'h0190);
      @(negedge clk);
      temp_a = 13'h0960;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      collectRecord("overlap", 0, 11, vecs[0].bytes, 1'b0, 11, 1'b0);
      applyStimulus(0, 13'h0960);
      collectRecord("after_overlap", 0, 11, vecs[5].bytes, 1'b0, 11, 1'b1);

      // Reset a few ns after the edge carrying the 4th transfer.
      applyStimulus(0, 13'h0190);
      collectRecord("rst_mid", 0, 11, vecs[0].bytes, 1'b0, 4, 1'b1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 checkOutput("rst_async", {22'd0, busy_a, valid_a, data_a}, 32'd0);
      repeat (2) @(negedge clk);
      temp_a = 13'h0960;
      start_a = 1'b1;
      rst = 1'b0;
      @(negedge clk);
      start_a = 1'b0;
      checkOutput("start_on_release", 32'(busy_a), 32'd0);
      quiet = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (valid_a || busy_a) quiet++;
      end
      checkOutput("quiet_after_reset", 32'(quiet), 32'd0);
      applyStimulus(0, 13'h1FFF);
      collectRecord("post_reset", 0, 11, vecs[1].bytes, 1'b0, 11, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
